// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST controller.
// The LFSR and the MISR share one feedback polynomial: x^8+x^6+x^5+x^4+1.
package s27_bist_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRun,
    StDone
  } state_e;

  // Feedback taps on bits 7, 5, 4 and 3.
  localparam logic [7:0]  TapMask    = 8'hB8;
  localparam logic [3:0]  InitPat    = 4'b0111;
  localparam int unsigned InitCycles = 2;

  // One Fibonacci shift step: shift left and feed back the parity of the tapped bits.
  function automatic logic [7:0] tap_shift(input logic [7:0] v);
    return {v[6:0], ^(v & TapMask)};
  endfunction

endpackage

// File: rtl/s27_bist_if.sv
// Signals between the BIST controller and its surroundings: the s27 pattern/response
// pair, the start request and the status/signature outputs.
interface s27_bist_if;
  logic       start;
  logic [3:0] pat;
  logic       g17;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] sig;

  modport master (
    input  start,
    input  g17,
    output pat,
    output busy,
    output done,
    output pass,
    output sig
  );

  modport slave (
    output start,
    output g17,
    input  pat,
    input  busy,
    input  done,
    input  pass,
    input  sig
  );
endinterface

// File: rtl/s27_misr.sv
// 8-bit single-input signature register; the next value is also exported so that
// the pass/fail decision can be made on the same edge as the final update.
module s27_misr
  import s27_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       clr,
  input  logic       din,
  output logic [7:0] sig,
  output logic [7:0] sig_next
);

  logic [7:0] sig_q;

  always_comb begin
    sig_next = tap_shift(sig_q) ^ {7'b0, din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_q <= 8'h00;
    end else if (clr) begin
      sig_q <= 8'h00;
    end else if (en) begin
      sig_q <= sig_next;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/s27_bist.sv
// BIST controller around the s27 benchmark: an LFSR drives G0-G3, G17 is compacted
// into a MISR, and the final signature is compared against GOLDEN.
module s27_bist
  import s27_bist_pkg::*;
#(
  parameter int unsigned N_PATTERNS = 64,
  parameter logic [7:0]  LFSR_SEED  = 8'h01,
  parameter logic [7:0]  GOLDEN     = 8'h00
) (
  input  logic          clk,
  input  logic          rst_n,
  s27_bist_if.master    bus
);

  localparam logic [7:0] LastCount = 8'(N_PATTERNS - 1);
  localparam logic [7:0] LastInit  = 8'(InitCycles - 1);

  state_e     state_q;
  logic [7:0] lfsr_q;
  logic [7:0] lfsr_next;
  logic [7:0] count_q;
  logic [3:0] pat_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic       restart;
  logic       misr_en;
  logic [7:0] sig;
  logic [7:0] sig_next;

  assign lfsr_next = tap_shift(lfsr_q);
  assign restart   = bus.start && (state_q == StIdle || state_q == StDone);
  assign misr_en   = (state_q == StRun);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      count_q <= 8'h00;
      pat_q   <= 4'h0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (restart) begin
            state_q <= StInit;
            lfsr_q  <= LFSR_SEED;
            count_q <= 8'h00;
            pat_q   <= InitPat;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
          end
        end
        StInit: begin
          if (count_q == LastInit) begin
            state_q <= StRun;
            count_q <= 8'h00;
            pat_q   <= lfsr_q[3:0];
          end else begin
            count_q <= count_q + 8'd1;
          end
        end
        StRun: begin
          // G17 seen on this edge belongs to the pattern currently on pat_q.
          lfsr_q  <= lfsr_next;
          pat_q   <= lfsr_next[3:0];
          count_q <= count_q + 8'd1;
          if (count_q == LastCount) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (sig_next == GOLDEN);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  s27_misr u_misr (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (misr_en),
    .clr      (restart),
    .din      (bus.g17),
    .sig      (sig),
    .sig_next (sig_next)
  );

  assign bus.pat  = pat_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.sig  = sig;

  // A zero seed locks the LFSR at zero.
  a_lfsr_nonzero : assert property (@(posedge clk) disable iff (!rst_n) lfsr_q != 8'h00)
    else $error("s27_bist: LFSR is zero (LFSR_SEED must be nonzero)");

endmodule

// File: tb/tb_s27_bist.sv
// Directed bench for s27_bist: reset, pattern order, MISR arithmetic, closed loop
// against a behavioural s27, mid-run reset and START during RUN.
module tb_s27_bist;

  logic clk;
  logic rst_n;
  logic use_s27;
  int   n_cmp;
  int   n_err;
  logic [7:0] exp_sig;

  s27_bist_if bus0 ();
  s27_bist_if bus1 ();
  s27_bist_if bus2 ();

  s27_bist u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  s27_bist #(.N_PATTERNS(2), .LFSR_SEED(8'h01), .GOLDEN(8'h00)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  s27_bist #(.N_PATTERNS(2), .LFSR_SEED(8'h01), .GOLDEN(8'h03)) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // s27 netlist; st = {G5,G6,G7}, returns {G17, next G5, next G6, next G7}.
  function automatic logic [3:0] s27_eval(input logic [3:0] p, input logic [2:0] st);
    logic g14, g8, g12, g15, g16, g9, g11, g10, g13;
    g14 = ~p[0];
    g8  = g14 & st[1];
    g12 = ~(p[1] | st[0]);
    g15 = g12 | g8;
    g16 = p[3] | g8;
    g9  = ~(g16 & g15);
    g11 = ~(st[2] | g9);
    g10 = ~(g14 | g11);
    g13 = ~(p[2] | g12);
    return {~g11, g10, g11, g13};
  endfunction

  logic [2:0] s27_q;
  logic [3:0] s27_r;
  always_comb s27_r = s27_eval(bus0.pat, s27_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s27_q <= 3'b000;
    else        s27_q <= s27_r[2:0];
  end

  assign bus0.g17 = use_s27 & s27_r[3];
  assign bus1.g17 = 1'b1;
  assign bus2.g17 = 1'b1;

  // Cycle-level reference of LFSR + s27 + MISR for the default 64-pattern run.
  function automatic logic [7:0] ref_sig();
    logic [2:0] st;
    logic [7:0] l;
    logic [7:0] s;
    logic [3:0] r;
    st = 3'b000;
    l  = 8'h01;
    s  = 8'h00;
    for (int i = 0; i < 2; i++) begin
      r  = s27_eval(4'b0111, st);
      st = r[2:0];
    end
    for (int i = 0; i < 64; i++) begin
      r  = s27_eval(l[3:0], st);
      s  = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]} ^ {7'b0, r[3]};
      st = r[2:0];
      l  = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Leaves the bench at the negedge following e0.
  task automatic start_pulse0();
    @(negedge clk);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
  endtask

  // Full 64-pattern run on dut0, optional extra START pulses on edges pa/pb.
  task automatic run0(input string tag, input int pa, input int pb);
    start_pulse0();
    for (int k = 0; k < 66; k++) begin
      if (k == 65) check({tag, "_done_e65"}, 32'(bus0.done), 32'd0);
      bus0.start = ((k + 1) == pa) || ((k + 1) == pb);
      @(negedge clk);
    end
    bus0.start = 1'b0;
    check({tag, "_done_e66"}, 32'(bus0.done), 32'd1);
    check({tag, "_busy_e66"}, 32'(bus0.busy), 32'd0);
  endtask

  initial begin
    logic [3:0] pat_exp [8];
    pat_exp = '{4'h7, 4'h7, 4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h3};
    n_cmp = 0;
    n_err = 0;
    use_s27 = 1'b0;
    bus0.start = 1'b0;
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    rst_n = 1'b0;

    // Reset values, held and after release with START low.
    repeat (2) @(negedge clk);
    check("rst_pat",  32'(bus0.pat),  32'h0);
    check("rst_busy", 32'(bus0.busy), 32'h0);
    check("rst_done", 32'(bus0.done), 32'h0);
    check("rst_pass", 32'(bus0.pass), 32'h0);
    check("rst_sig",  32'(bus0.sig),  32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_pat",  32'(bus0.pat),  32'h0);
    check("idle_busy", 32'(bus0.busy), 32'h0);
    check("idle_sig",  32'(bus0.sig),  32'h0);

    // Pattern order with G17 tied low.
    start_pulse0();
    for (int k = 0; k < 8; k++) begin
      check($sformatf("pat_e%0d", k), 32'(bus0.pat), 32'(pat_exp[k]));
      check($sformatf("sig0_e%0d", k), 32'(bus0.sig), 32'h0);
      @(negedge clk);
    end
    check("busy_run", 32'(bus0.busy), 32'h1);
    for (int k = 8; k < 66; k++) begin
      if (k == 65) check("po_done_e65", 32'(bus0.done), 32'd0);
      @(negedge clk);
    end
    check("po_done_e66", 32'(bus0.done), 32'd1);
    check("po_pass",     32'(bus0.pass), 32'd1);
    check("po_sig",      32'(bus0.sig),  32'h00);

    // MISR arithmetic, G17 tied high, N_PATTERNS=2.
    @(negedge clk);
    bus1.start = 1'b1;
    bus2.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    bus2.start = 1'b0;
    repeat (3) @(negedge clk);
    check("m_sig_e3", 32'(bus1.sig),  32'h01);
    check("m_run_e3", 32'(bus1.done), 32'h0);
    @(negedge clk);
    check("m_sig_e4",   32'(bus1.sig),  32'h03);
    check("m_done_e4",  32'(bus1.done), 32'h1);
    check("m_pass_g0",  32'(bus1.pass), 32'h0);
    check("m_pass_g3",  32'(bus2.pass), 32'h1);
    check("m_sig2_e4",  32'(bus2.sig),  32'h03);

    // Restart from DONE: DONE and PASS drop on the next edge.
    bus2.start = 1'b1;
    @(negedge clk);
    bus2.start = 1'b0;
    check("rs_done", 32'(bus2.done), 32'h0);
    check("rs_pass", 32'(bus2.pass), 32'h0);
    check("rs_busy", 32'(bus2.busy), 32'h1);
    check("rs_sig",  32'(bus2.sig),  32'h00);

    // Closed loop against the behavioural s27.
    use_s27 = 1'b1;
    exp_sig = ref_sig();
    run0("cl1", -1, -1);
    check("cl1_sig",  32'(bus0.sig),  32'(exp_sig));
    check("cl1_pass", 32'(bus0.pass), 32'(exp_sig == 8'h00));
    run0("cl2", -1, -1);
    check("cl2_sig",  32'(bus0.sig),  32'(exp_sig));

    // Asynchronous reset in the middle of a run.
    start_pulse0();
    repeat (19) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mr_pat",  32'(bus0.pat),  32'h0);
    check("mr_busy", 32'(bus0.busy), 32'h0);
    check("mr_done", 32'(bus0.done), 32'h0);
    check("mr_pass", 32'(bus0.pass), 32'h0);
    check("mr_sig",  32'(bus0.sig),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    run0("mr", -1, -1);
    check("mr_sig_rerun", 32'(bus0.sig), 32'(exp_sig));

    // START pulses while busy are ignored.
    run0("sb", 5, 30);
    check("sb_sig", 32'(bus0.sig), 32'(exp_sig));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/s27_bist.md
# s27_bist

Built-in self-test controller for the s27 sequential benchmark. Drives s27 inputs G0–G3 from an on-chip LFSR and compacts output G17 into an 8-bit MISR signature. Sits directly around s27 on the same clock: upstream as pattern source, downstream as response consumer. Flags pass/fail against a golden signature.

## Interface
- N_PATTERNS, default 64: number of RUN cycles (1..255).
- LFSR_SEED, default 8'h01: LFSR value loaded on START; nonzero.
- GOLDEN, default 8'h00: expected final signature.
- CK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous, active-low reset.
- START  in  1  level-sampled request; acted on only in IDLE or DONE.
- PAT  out  4  to s27: PAT[0]→G0, PAT[1]→G1, PAT[2]→G2, PAT[3]→G3.
- G17  in  1  s27 output.
- BUSY  out  1  high in INIT and RUN.
- DONE  out  1  high in DONE.
- PASS  out  1  SIG==GOLDEN, valid while DONE.
- SIG  out  8  MISR signature.

## Operation
- All outputs registered. Reset values: PAT=0, BUSY=0, DONE=0, PASS=0, SIG=0, state IDLE, LFSR=LFSR_SEED, count=0.
- States:
  - IDLE: START → INIT; load LFSR=LFSR_SEED, SIG=0, count=0.
  - INIT: 2 cycles, PAT=4'b0111 (G0=1, G1=1, G2=1, G3=0). This forces s27 state to (G5,G6,G7)=(1,0,0) after one edge from any start state; second cycle is margin. Then → RUN.
  - RUN: PAT=LFSR[3:0]. Each edge:
    - LFSR and MISR update.
    - count increments.
    - After N_PATTERNS edges → DONE.
  - DONE: SIG and PASS held. START → INIT with same reload as IDLE.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1.
  - next = {L[6:0], L[7]^L[5]^L[4]^L[3]}.
  - Sequence from 8'h01: 01, 02, 04, 08, 11, 23, …
- MISR: SIG_next = {S[6:0], S[7]^S[5]^S[4]^S[3]} ^ {7'b0, G17}.
  - G17 is sampled on every RUN edge only; no MISR update in other states.
- PASS is registered on the RUN→DONE edge from the final SIG_next. It is cleared on leaving DONE.
- count width is 8 bits; N_PATTERNS=255 is the maximum, no wrap.
- Boundary behaviour:
  - START while BUSY: ignored.
  - START held high in DONE: restarts immediately, DONE drops next edge.
  - RSTN low at any time: immediate return to reset values, including mid-RUN; no partial result is retained.
  - LFSR never reaches 0 with a nonzero seed. LFSR_SEED=0 is illegal; an assertion fires in simulation.

## Timing
- Edges are counted from the START-sampling edge (e0).
  - e0: state=INIT, BUSY=1, PAT=0x7.
  - e2: state=RUN, PAT=LFSR_SEED[3:0].
  - e(2+N_PATTERNS): state=DONE, BUSY=0, DONE=1, PASS valid, SIG final.
- G17 is combinational from PAT and s27 state. The MISR samples it on the same edge that advances PAT, so response latency is 0 cycles relative to the applied pattern.
- Total test latency: N_PATTERNS+2 cycles.

## Structure
- Package s27_bist_pkg holds:
  - state enum {IDLE, INIT, RUN, DONE};
  - LFSR/MISR tap mask 8'hB8 (bits 7, 5, 4, 3);
  - INIT_PAT=4'b0111;
  - INIT_CYCLES=2.
- One sub-module, s27_misr: 8-bit shift register with tap feedback, serial input, enable, and clear. The top level holds the FSM, LFSR and counter.
- Integration: the top-level harness instantiates s27_bist and s27 on a shared CK.

## Test plan
- Reset: hold RSTN=0 → PAT=0, BUSY=0, DONE=0, PASS=0, SIG=0x00. Release with START=0 → everything stays 0.
- Pattern order: START pulse, G17 tied 0 → PAT is 0x7, 0x7, then 0x1, 0x2, 0x4, 0x8, 0x1, 0x3. SIG stays 0x00. DONE rises at e66. PASS=1 with GOLDEN=0.
- MISR arithmetic: N_PATTERNS=2, G17 tied 1 → SIG 0x01 then 0x03. PASS=0 with GOLDEN=0, PASS=1 with GOLDEN=8'h03.
- Closed loop: real s27 attached, default parameters → SIG matches the value from a cycle-accurate reference model of s27+LFSR. Rerunning START from DONE gives an identical SIG.
- Reset mid-run: RSTN low at e20 → all outputs zero asynchronously. A new START then reproduces the first-run SIG exactly.
- START during RUN: extra START pulses at e5 and e30 → no effect on SIG or DONE timing (DONE still at e66).
